instruction_sequencer: RTL and testbench

Consumer end of the program-counter interface. Takes the counter's address, fetches from the synchronous program ROM and decodes the 4-bit MC14500B opcode. Drives the counter's load port for JMP/RTN. Handles SKZ skips, squashes instructions already in flight, and keeps a small return-address stack, so JMP acts as a call and RTN as a return.

---
 rtl/mc14500_pkg.sv | 31 +++
 rtl/return_stack.sv | 57 +++++
 rtl/instruction_sequencer.sv | 129 ++++++++++++
 tb/tb_instruction_sequencer.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/mc14500_pkg.sv
// Shared definitions for the MC14500B instruction path: opcode encoding and
// instruction-word geometry.
package mc14500_pkg;

    localparam int OPC_W = 4;

    typedef enum logic [OPC_W-1:0] {
        OP_NOPO = 4'h0,
        OP_LD   = 4'h1,
        OP_LDC  = 4'h2,
        OP_AND  = 4'h3,
        OP_ANDC = 4'h4,
        OP_OR   = 4'h5,
        OP_ORC  = 4'h6,
        OP_XNOR = 4'h7,
        OP_STO  = 4'h8,
        OP_STOC = 4'h9,
        OP_IEN  = 4'hA,
        OP_OEN  = 4'hB,
        OP_JMP  = 4'hC,
        OP_RTN  = 4'hD,
        OP_SKZ  = 4'hE,
        OP_NOPF = 4'hF
    } opcode_t;

    // Instruction word is the opcode field stacked above the address-wide operand.
    function automatic int instr_width(input int addr_w);
        return addr_w + OPC_W;
    endfunction

endpackage

// File: rtl/return_stack.sv
// Circular return-address stack: a push when full overwrites the oldest entry,
// a pop when empty is ignored.
module return_stack #(
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] din,
    output logic [ADDR_W-1:0] top,
    output logic              empty,
    output logic              full
);

    localparam int PTR_W = $clog2(STACK_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [PTR_W:0]   CNT_ONE  = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [PTR_W:0]   CNT_ZERO = {(PTR_W+1){1'b0}};
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(STACK_DEPTH);

    logic [ADDR_W-1:0] mem_r [STACK_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W:0]    count_r;
    logic [PTR_W-1:0]  top_ptr_s;

    // wr_ptr_r names the next free slot, which is also the oldest entry once full.
    assign top_ptr_s = wr_ptr_r - PTR_ONE;
    assign top       = mem_r[top_ptr_s];
    assign empty     = (count_r == CNT_ZERO);
    assign full      = (count_r == CNT_FULL);

    // Entry storage; contents are meaningless while empty, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= CNT_ZERO;
        end else if (push) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (!full) begin
                count_r <= count_r + CNT_ONE;
            end
        end else if (pop && !empty) begin
            wr_ptr_r <= wr_ptr_r - PTR_ONE;
            count_r  <= count_r - CNT_ONE;
        end
    end

endmodule

// File: rtl/instruction_sequencer.sv
// Fetch/decode end of the program-counter loop: decodes the ROM word, steers
// JMP/RTN through a return stack and squashes skipped or flushed instructions.
module instruction_sequencer
    import mc14500_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [ADDR_W-1:0]              pc_addr,
    output logic [ADDR_W-1:0]              rom_addr,
    input  logic [instr_width(ADDR_W)-1:0] rom_data,
    input  logic                           rr,
    output logic                           pc_write,
    output logic [ADDR_W-1:0]              pc_target,
    output logic                           instr_valid,
    output logic [OPC_W-1:0]               opcode,
    output logic [ADDR_W-1:0]              operand,
    output logic                           jmp_flag,
    output logic                           rtn_flag,
    output logic                           flag_o,
    output logic                           flag_f,
    output logic                           stk_ovf,
    output logic                           stk_unf
);

    logic              fetch_valid_r;
    logic              squash_r;
    logic              stk_ovf_r;
    logic              stk_unf_r;
    logic              live_s;
    logic              squash_next_s;
    logic              unf_set_s;
    logic              stk_push_s;
    logic              stk_pop_s;
    logic              stk_empty_s;
    logic              stk_full_s;
    logic [ADDR_W-1:0] stk_top_s;
    opcode_t           opc_s;

    assign rom_addr    = pc_addr;
    assign opcode      = rom_data[ADDR_W+OPC_W-1:ADDR_W];
    assign operand     = rom_data[ADDR_W-1:0];
    assign opc_s       = opcode_t'(opcode);
    // Reset gates the decode directly so it wins in the very cycle it rises.
    assign live_s      = fetch_valid_r & ~squash_r & ~reset;
    assign instr_valid = live_s;
    assign stk_ovf     = stk_ovf_r;
    assign stk_unf     = stk_unf_r;

    // Decode of the live instruction into strobes, stack commands and next squash.
    always_comb begin
        pc_write      = 1'b0;
        pc_target     = operand;
        jmp_flag      = 1'b0;
        rtn_flag      = 1'b0;
        flag_o        = 1'b0;
        flag_f        = 1'b0;
        squash_next_s = 1'b0;
        unf_set_s     = 1'b0;
        stk_push_s    = 1'b0;
        stk_pop_s     = 1'b0;
        if (live_s) begin
            case (opc_s)
                OP_JMP: begin
                    pc_write      = 1'b1;
                    jmp_flag      = 1'b1;
                    stk_push_s    = 1'b1;
                    squash_next_s = 1'b1;
                end
                OP_RTN: begin
                    rtn_flag = 1'b1;
                    if (!stk_empty_s) begin
                        pc_write      = 1'b1;
                        pc_target     = stk_top_s;
                        stk_pop_s     = 1'b1;
                        squash_next_s = 1'b1;
                    end else begin
                        unf_set_s = 1'b1;
                    end
                end
                OP_SKZ: begin
                    squash_next_s = ~rr;
                end
                OP_NOPO: flag_o = 1'b1;
                OP_NOPF: flag_f = 1'b1;
                default: squash_next_s = 1'b0;
            endcase
        end else begin
            squash_next_s = 1'b0;
        end
    end

    // Pipeline-state registers and sticky stack error flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_valid_r <= 1'b0;
            squash_r      <= 1'b0;
            stk_ovf_r     <= 1'b0;
            stk_unf_r     <= 1'b0;
        end else begin
            fetch_valid_r <= 1'b1;
            squash_r      <= squash_next_s;
            if (stk_push_s && stk_full_s) begin
                stk_ovf_r <= 1'b1;
            end
            if (unf_set_s) begin
                stk_unf_r <= 1'b1;
            end
        end
    end

    // pc_addr during decode is already JMP+1, so it is pushed unmodified.
    return_stack #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_return_stack (
        .clk   (clk),
        .reset (reset),
        .push  (stk_push_s),
        .pop   (stk_pop_s),
        .din   (pc_addr),
        .top   (stk_top_s),
        .empty (stk_empty_s),
        .full  (stk_full_s)
    );

endmodule

// File: tb/tb_instruction_sequencer.sv
// Bench for instruction_sequencer: a program counter and synchronous ROM close
// the loop, a program-level model predicts every cycle, directed checks pin it.
module tb_instruction_sequencer;

    localparam int AW    = 8;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] pc;
    logic [AW-1:0] rom_addr;
    logic [11:0]   rom_data;
    logic [AW-1:0] rom_addr_q;
    logic          rr;
    logic          pc_write;
    logic [AW-1:0] pc_target;
    logic          instr_valid;
    logic [3:0]    opcode;
    logic [AW-1:0] operand;
    logic          jmp_flag, rtn_flag, flag_o, flag_f, stk_ovf, stk_unf;

    logic [11:0]   rom [256];
    int            n_checks = 0;
    int            n_errors = 0;

    always #5 clk = ~clk;

    instruction_sequencer #(.ADDR_W(AW), .STACK_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .pc_addr(pc), .rom_addr(rom_addr),
        .rom_data(rom_data), .rr(rr), .pc_write(pc_write), .pc_target(pc_target),
        .instr_valid(instr_valid), .opcode(opcode), .operand(operand),
        .jmp_flag(jmp_flag), .rtn_flag(rtn_flag), .flag_o(flag_o), .flag_f(flag_f),
        .stk_ovf(stk_ovf), .stk_unf(stk_unf)
    );

    // Environment: program counter, synchronous ROM, and rr = 1 only for the word at 0x06.
    always @(posedge clk) begin
        if (reset) pc <= 8'h00;
        else if (pc_write) pc <= pc_target;
        else pc <= pc + 8'h01;
        rom_data   <= rom[rom_addr];
        rom_addr_q <= rom_addr;
    end
    assign rr = (rom_addr_q == 8'h06);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Program-level model: its own pc, the word it fetched, a queue as stack.
    logic [AW-1:0] m_pc = 8'h00;
    logic [11:0]   m_word = 12'h000;
    bit            m_fv = 1'b0, m_sq = 1'b0, m_ovf = 1'b0, m_unf = 1'b0;
    logic [AW-1:0] m_stack [$];

    initial begin : model
        bit            e_rst, e_live, e_jmp, e_rtn, e_pcw, e_skz;
        logic [3:0]    e_opc;
        logic [AW-1:0] e_opnd, e_tgt;
        forever begin
            @(negedge clk);
            e_rst  = reset;
            e_opc  = m_word[11:8];
            e_opnd = m_word[7:0];
            e_live = !e_rst && m_fv && !m_sq;
            e_jmp  = e_live && e_opc == 4'hC;
            e_rtn  = e_live && e_opc == 4'hD;
            e_skz  = e_live && e_opc == 4'hE && !rr;
            e_pcw  = e_jmp || (e_rtn && m_stack.size() > 0);
            e_tgt  = e_jmp ? e_opnd : (e_pcw ? m_stack[$] : 8'h00);
            chk("rom_addr", rom_addr, m_pc);
            chk("instr_valid", instr_valid, e_live);
            chk("pc_write", pc_write, e_pcw);
            chk("jmp_flag", jmp_flag, e_jmp);
            chk("rtn_flag", rtn_flag, e_rtn);
            chk("flag_o", flag_o, e_live && e_opc == 4'h0);
            chk("flag_f", flag_f, e_live && e_opc == 4'hF);
            chk("stk_ovf", stk_ovf, m_ovf);
            chk("stk_unf", stk_unf, m_unf);
            if (e_pcw) chk("pc_target", pc_target, e_tgt);
            if (e_live) begin
                chk("opcode", opcode, e_opc);
                chk("operand", operand, e_opnd);
            end
            @(posedge clk);
            m_word = rom[m_pc];
            if (e_rst) begin
                m_pc = 8'h00; m_fv = 1'b0; m_sq = 1'b0;
                m_ovf = 1'b0; m_unf = 1'b0;
                m_stack.delete();
            end else begin
                if (e_jmp) begin
                    m_stack.push_back(m_pc);
                    if (m_stack.size() > DEPTH) begin
                        void'(m_stack.pop_front());
                        m_ovf = 1'b1;
                    end
                end
                if (e_rtn) begin
                    if (m_stack.size() > 0) void'(m_stack.pop_back());
                    else m_unf = 1'b1;
                end
                m_sq = e_pcw || e_skz;
                m_pc = e_pcw ? e_tgt : m_pc + 8'h01;
                m_fv = 1'b1;
            end
        end
    end

    // Directed program and hand-computed expectations per cycle after reset release.
    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 12'h000;
        rom[8'h00] = 12'h105; rom[8'h01] = 12'h000; rom[8'h02] = 12'hC40;
        rom[8'h03] = 12'h101; rom[8'h04] = 12'hE00; rom[8'h05] = 12'hC10;
        rom[8'h06] = 12'hE00; rom[8'h07] = 12'hC10; rom[8'h08] = 12'hC20;
        rom[8'h10] = 12'hD00; rom[8'h40] = 12'hD00;
        rom[8'h20] = 12'hC30; rom[8'h21] = 12'hD00; rom[8'h22] = 12'hC60;
        rom[8'h30] = 12'hC38; rom[8'h31] = 12'hD00;
        rom[8'h38] = 12'hC48; rom[8'h39] = 12'hD00;
        rom[8'h48] = 12'hC50; rom[8'h49] = 12'hD00; rom[8'h50] = 12'hD00;
        rom[8'h60] = 12'hC68; rom[8'h68] = 12'hE00; rom[8'h69] = 12'h1AA;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            case (c)
                0:  chk("d_bubble", instr_valid, 32'd0);
                1:  begin chk("d_ld_valid", instr_valid, 32'd1); chk("d_ld_opc", opcode, 32'h1);
                          chk("d_ld_opnd", operand, 32'h05); end
                2:  chk("d_nopo_flag", flag_o, 32'd1);
                3:  begin chk("d_jmp_pcw", pc_write, 32'd1); chk("d_jmp_tgt", pc_target, 32'h40); end
                4:  chk("d_jmp_squash", instr_valid, 32'd0);
                5:  begin chk("d_rtn_opc", opcode, 32'hD); chk("d_rtn_tgt", pc_target, 32'h03);
                          chk("d_rtn_flag", rtn_flag, 32'd1); end
                6:  chk("d_rtn_squash", instr_valid, 32'd0);
                7:  begin chk("d_ret_valid", instr_valid, 32'd1); chk("d_ret_opnd", operand, 32'h01); end
                9:  begin chk("d_skz0_valid", instr_valid, 32'd0); chk("d_skz0_pcw", pc_write, 32'd0); end
                11: begin chk("d_skz1_valid", instr_valid, 32'd1); chk("d_skz1_tgt", pc_target, 32'h10); end
                13: chk("d_call_ret", pc_target, 32'h08);
                23: chk("d_ovf_before", stk_ovf, 32'd0);
                24: chk("d_ovf_after", stk_ovf, 32'd1);
                25: chk("d_lifo1", pc_target, 32'h49);
                27: chk("d_lifo2", pc_target, 32'h39);
                29: chk("d_lifo3", pc_target, 32'h31);
                31: chk("d_lifo4", pc_target, 32'h21);
                33: begin chk("d_empty_pcw", pc_write, 32'd0); chk("d_empty_rtn", rtn_flag, 32'd1); end
                34: chk("d_unf", stk_unf, 32'd1);
                39: begin chk("d_rst_valid", instr_valid, 32'd0); chk("d_rst_pcw", pc_write, 32'd0); end
                41: chk("d_rst_bubble", instr_valid, 32'd0);
                42: begin chk("d_rst_live", instr_valid, 32'd1); chk("d_rst_opc", opcode, 32'h1); end
                43: begin chk("d_rst_rtn", rtn_flag, 32'd1); chk("d_rst_rtn_pcw", pc_write, 32'd0); end
                44: begin chk("d_rst_unf", stk_unf, 32'd1); chk("d_rst_ovf", stk_ovf, 32'd0); end
                default: ;
            endcase
            @(posedge clk);
            #1;
            if (c == 38) reset = 1'b1;
            if (c == 39) rom[8'h01] = 12'hD00;
            if (c == 40) reset = 1'b0;
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
